// File: rtl/pu_pkg.sv
// Shared definitions for the PU sequencer: state encoding, fixed PU timing and
// default datapath dimensions shared with pu_2.
package pu_pkg;

  localparam int unsigned PU_DATA_WIDTH = 8;
  localparam int unsigned PU_MAC_CNT    = 32;

  // Cycles between the last read enable and the requantise pulse.
  localparam int unsigned DRAIN_CYC     = 3;
  // Nominal relu_en -> done latency inside the PU.
  localparam int unsigned PU_DONE_LAT   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    RELU  = 3'd3,
    WAIT  = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/pu_seq_ctrl_if.sv
// Buffer/PU-side bus of the sequencer: input buffer, weight ROM, PU control
// and output buffer. master = sequencer, slave = memories and PU.
interface pu_seq_ctrl_if
  import pu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PU_DATA_WIDTH,
  parameter int unsigned MAC_CNT    = PU_MAC_CNT,
  parameter int unsigned IN_AW      = 10,
  parameter int unsigned W_AW       = 12,
  parameter int unsigned O_AW       = 2
);

  logic                          in_re;
  logic [IN_AW-1:0]              in_addr;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          w_re;
  logic [W_AW-1:0]               w_addr;
  logic                          pu_mac_en;
  logic                          pu_relu_en;
  logic                          pu_mac_clear;
  logic [DATA_WIDTH-1:0]         pu_din;
  logic                          pu_done;
  logic [DATA_WIDTH*MAC_CNT-1:0] pu_matmul;
  logic                          out_we;
  logic [O_AW-1:0]               out_addr;
  logic [DATA_WIDTH*MAC_CNT-1:0] out_data;

  modport master (
    output in_re, in_addr, w_re, w_addr,
    input  in_data,
    output pu_mac_en, pu_relu_en, pu_mac_clear, pu_din,
    input  pu_done, pu_matmul,
    output out_we, out_addr, out_data
  );

  modport slave (
    input  in_re, in_addr, w_re, w_addr,
    output in_data,
    input  pu_mac_en, pu_relu_en, pu_mac_clear, pu_din,
    output pu_done, pu_matmul,
    input  out_we, out_addr, out_data
  );

endinterface

// File: rtl/pu_addr_gen.sv
// Address generation for the PU sequencer: step counter k, tile counter and
// an accumulating weight-row register (tile*IN_LEN + k without a multiplier).
module pu_addr_gen #(
  parameter int unsigned IN_LEN    = 784,
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned IN_AW     = 10,
  parameter int unsigned W_AW      = 12,
  parameter int unsigned O_AW      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             k_inc_i,
  input  logic             tile_inc_i,
  output logic [IN_AW-1:0] in_addr_o,
  output logic [W_AW-1:0]  w_addr_o,
  output logic [O_AW-1:0]  tile_o,
  output logic             last_k_o,
  output logic             last_tile_o
);

  logic [IN_AW-1:0] k_q,    k_d;
  logic [W_AW-1:0]  w_q,    w_d;
  logic [O_AW-1:0]  tile_q, tile_d;

  assign last_k_o    = (k_q == IN_AW'(IN_LEN - 1));
  assign last_tile_o = (tile_q == O_AW'(NUM_TILES - 1));

  // The weight row advances with k, so after the last step of a tile it
  // already holds the next tile's base address.
  always_comb begin
    k_d    = k_q;
    w_d    = w_q;
    tile_d = tile_q;
    if (clear_i) begin
      k_d    = '0;
      w_d    = '0;
      tile_d = '0;
    end else begin
      if (k_inc_i) begin
        k_d = last_k_o ? '0 : k_q + IN_AW'(1);
        w_d = w_q + W_AW'(1);
      end
      if (tile_inc_i) begin
        tile_d = tile_q + O_AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q    <= '0;
      w_q    <= '0;
      tile_q <= '0;
    end else begin
      k_q    <= k_d;
      w_q    <= w_d;
      tile_q <= tile_d;
    end
  end

  assign in_addr_o = k_q;
  assign w_addr_o  = w_q;
  assign tile_o    = tile_q;

endmodule

// File: rtl/pu_seq_ctrl.sv
// Layer sequencer for the 32-lane MAC PU: feeds inputs/weights per tile,
// fires requantise, waits for PU done and stores each tile result.
// Optional PU_TIMEOUT_EN adds a WAIT watchdog that raises err_o.
module pu_seq_ctrl
  import pu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PU_DATA_WIDTH,
  parameter int unsigned MAC_CNT     = PU_MAC_CNT,
  parameter int unsigned IN_LEN      = 784,
  parameter int unsigned NUM_TILES   = 4,
  parameter int unsigned IN_AW       = 10,
  parameter int unsigned W_AW        = 12,
  parameter int unsigned O_AW        = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  pu_seq_ctrl_if.master  bus
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC);
  localparam int unsigned RES_W   = DATA_WIDTH * MAC_CNT;

  // Elaboration-time parameter sanity.
  if (IN_AW < $clog2(IN_LEN)) begin : g_bad_in_aw
    $error("IN_AW too narrow for IN_LEN");
  end
  if (W_AW < $clog2(IN_LEN * NUM_TILES)) begin : g_bad_w_aw
    $error("W_AW too narrow for IN_LEN*NUM_TILES");
  end
  if (O_AW < 1 || O_AW < $clog2(NUM_TILES)) begin : g_bad_o_aw
    $error("O_AW too narrow for NUM_TILES");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  seq_state_e         state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               in_re_q, in_re_d;
  logic               mac_en_q, mac_en_d;
  logic               relu_q, relu_d;
  logic               clear_q, clear_d;
  logic               we_q, we_d;
  logic [O_AW-1:0]    out_addr_q, out_addr_d;
  logic [RES_W-1:0]   out_data_q, out_data_d;

  logic               ag_clear, ag_k_inc, ag_tile_inc;
  logic [IN_AW-1:0]   ag_in_addr;
  logic [W_AW-1:0]    ag_w_addr;
  logic [O_AW-1:0]    ag_tile;
  logic               ag_last_k, ag_last_tile;

`ifdef PU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic            err_q, err_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  pu_addr_gen #(
    .IN_LEN    (IN_LEN),
    .NUM_TILES (NUM_TILES),
    .IN_AW     (IN_AW),
    .W_AW      (W_AW),
    .O_AW      (O_AW)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (ag_clear),
    .k_inc_i     (ag_k_inc),
    .tile_inc_i  (ag_tile_inc),
    .in_addr_o   (ag_in_addr),
    .w_addr_o    (ag_w_addr),
    .tile_o      (ag_tile),
    .last_k_o    (ag_last_k),
    .last_tile_o (ag_last_tile)
  );

  // Next state, then registered outputs decoded from the state being entered.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    out_data_d  = out_data_q;
    ag_clear    = 1'b0;
    ag_k_inc    = 1'b0;
    ag_tile_inc = 1'b0;
`ifdef PU_TIMEOUT_EN
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = FEED;
          ag_clear = 1'b1;
`ifdef PU_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      FEED: begin
        ag_k_inc = 1'b1;
        if (ag_last_k) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d = RELU;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      RELU: begin
        state_d = WAIT;
`ifdef PU_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (bus.pu_done) begin
          state_d = STORE;
`ifdef PU_TIMEOUT_EN
        end else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
        end
      end
      STORE: begin
        if (ag_last_tile) begin
          state_d = DONE;
        end else begin
          state_d     = FEED;
          ag_tile_inc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_re_d    = (state_d == FEED);
    mac_en_d   = in_re_q;
    relu_d     = (state_d == RELU);
    we_d       = (state_d == STORE);
    clear_d    = (state_d == STORE);
    out_addr_d = (state_d == STORE) ? ag_tile : '0;
    done_d     = (state_d == DONE);
    if (state_d == STORE) begin
      out_data_d = bus.pu_matmul;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_re_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      relu_q      <= 1'b0;
      clear_q     <= 1'b0;
      we_q        <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
`ifdef PU_TIMEOUT_EN
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_re_q     <= in_re_d;
      mac_en_q    <= mac_en_d;
      relu_q      <= relu_d;
      clear_q     <= clear_d;
      we_q        <= we_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
`ifdef PU_TIMEOUT_EN
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

`ifdef PU_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign bus.in_re        = in_re_q;
  assign bus.w_re         = in_re_q;
  assign bus.in_addr      = ag_in_addr;
  assign bus.w_addr       = ag_w_addr;
  assign bus.pu_mac_en    = mac_en_q;
  assign bus.pu_relu_en   = relu_q;
  assign bus.pu_mac_clear = clear_q;
  // Read data goes straight to the PU; mac_en is delayed to line up with it.
  assign bus.pu_din       = bus.in_data;
  assign bus.out_we       = we_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_data     = out_data_q;

endmodule

// File: tb/tb_pu_seq_ctrl.sv
// Scoreboard bench for pu_seq_ctrl (IN_LEN=4, NUM_TILES=2) with a behavioural
// input buffer and PU model; covers PU_TIMEOUT_EN when that macro is defined.
module tb_pu_seq_ctrl;

  localparam int unsigned DW     = 8;
  localparam int unsigned MC     = 32;
  localparam int unsigned IN_LEN = 4;
  localparam int unsigned NT     = 2;
  localparam int unsigned IN_AW  = 3;
  localparam int unsigned W_AW   = 3;
  localparam int unsigned O_AW   = 1;
  localparam int unsigned TO     = 16;

  typedef struct { logic [O_AW-1:0] addr; logic [DW*MC-1:0] data; } out_exp_t;
  typedef struct { int cyc; logic err; } done_exp_t;

  logic clk = 1'b0;
  logic rst_i, start_i;
  logic busy_o, done_o, err_o;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  pu_seq_ctrl_if #(.DATA_WIDTH(DW), .MAC_CNT(MC), .IN_AW(IN_AW), .W_AW(W_AW), .O_AW(O_AW)) bus ();

  pu_seq_ctrl #(
    .DATA_WIDTH(DW), .MAC_CNT(MC), .IN_LEN(IN_LEN), .NUM_TILES(NT),
    .IN_AW(IN_AW), .W_AW(W_AW), .O_AW(O_AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int        exp_in_q[$];
  int        exp_w_q[$];
  int        exp_din_q[$];
  out_exp_t  exp_out_q[$];
  done_exp_t exp_done_q[$];
  int        exp_relu_n = 0;
  bit        mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic logic [DW*MC-1:0] vec(input int n);
    logic [DW*MC-1:0] v;
    for (int i = 0; i < int'(MC); i++) v[i*8 +: 8] = 8'(i + 1 + n * 32);
    return v;
  endfunction

  // Input buffer: byte k holds 0x10+k, one-cycle read latency.
  always @(posedge clk) if (bus.in_re) bus.in_data <= 8'h10 + {5'd0, bus.in_addr};

  // PU model: result vector latched on relu_en, done pu_delay cycles later.
  int   pu_delay = 5;
  bit   pu_never = 1'b0;
  int   relu_cnt = 0;
  int   dly_cnt = 0;
  logic model_done = 1'b0;
  logic spur = 1'b0;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (bus.pu_relu_en) begin
      bus.pu_matmul <= vec(relu_cnt);
      relu_cnt      <= relu_cnt + 1;
      dly_cnt       <= 1;
    end else if (dly_cnt != 0) begin
      if (!pu_never && dly_cnt == pu_delay - 1) begin
        model_done <= 1'b1;
        dly_cnt    <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end
  end
  assign bus.pu_done = model_done | spur;

  // Monitor: pops expectations whenever the DUT presents an output.
  logic      prev_in_re = 1'b0, prev_model_done = 1'b0, relu_prev = 1'b0;
  int        mac_gap = 0;
  int        e_i;
  out_exp_t  e_o;
  done_exp_t e_d;
  always @(negedge clk) if (mon_en) begin
    mac_gap = bus.pu_mac_en ? 0 : mac_gap + 1;
    if (bus.in_re) begin
      if (exp_in_q.size() == 0) chk("in_re_unexpected", 256'(bus.in_re), 256'(0));
      else begin
        e_i = exp_in_q.pop_front();
        chk("in_addr", 256'(bus.in_addr), 256'(e_i));
        e_i = exp_w_q.pop_front();
        chk("w_addr", 256'(bus.w_addr), 256'(e_i));
        chk("w_re", 256'(bus.w_re), 256'(1));
      end
    end
    if (bus.pu_mac_en) begin
      chk("mac_en_lag", 256'(prev_in_re), 256'(1));
      if (exp_din_q.size() == 0) chk("mac_en_unexpected", 256'(bus.pu_mac_en), 256'(0));
      else begin
        e_i = exp_din_q.pop_front();
        chk("pu_din", 256'(bus.pu_din), 256'(e_i));
      end
    end
    if (bus.pu_relu_en) begin
      chk("relu_gap", 256'(mac_gap), 256'(3));
      chk("relu_single", 256'(relu_prev), 256'(0));
    end
    if (bus.out_we) begin
      chk("store_after_done", 256'(prev_model_done), 256'(1));
      chk("mac_clear", 256'(bus.pu_mac_clear), 256'(1));
      if (exp_out_q.size() == 0) chk("out_we_unexpected", 256'(bus.out_we), 256'(0));
      else begin
        e_o = exp_out_q.pop_front();
        chk("out_addr", 256'(bus.out_addr), 256'(e_o.addr));
        chk("out_data", 256'(bus.out_data), 256'(e_o.data));
      end
    end
    if (done_o) begin
      chk("busy_at_done", 256'(busy_o), 256'(1));
      if (exp_done_q.size() == 0) chk("done_unexpected", 256'(done_o), 256'(0));
      else begin
        e_d = exp_done_q.pop_front();
        chk("done_cycle", 256'(cyc), 256'(e_d.cyc));
        chk("err_at_done", 256'(err_o), 256'(e_d.err));
      end
    end
    prev_in_re      = bus.in_re;
    prev_model_done = model_done;
    relu_prev       = bus.pu_relu_en;
  end

  // Edges from the start sample edge to the one opening the DONE cycle:
  // per tile IN_LEN feed + 3 drain + 1 relu + PU latency + 1 store.
  function automatic int layer_off(input int d);
    return int'(NT) * (int'(IN_LEN) + 3 + 1 + d + 1);
  endfunction

  task automatic start_layer(input bit hold, input int fed, input int stored,
                             input int done_off, input bit err_exp);
    @(negedge clk);
    start_i = 1'b1;
    for (int t = 0; t < fed; t++)
      for (int k = 0; k < int'(IN_LEN); k++) begin
        exp_in_q.push_back(k);
        exp_w_q.push_back(t * int'(IN_LEN) + k);
        exp_din_q.push_back(8'h10 + k);
      end
    for (int t = 0; t < stored; t++)
      exp_out_q.push_back('{addr: O_AW'(t), data: vec(exp_relu_n + t)});
    exp_relu_n += fed;
    @(posedge clk);
    #1;
    exp_done_q.push_back('{cyc: cyc + done_off, err: err_exp});
    start_i = hold;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_o) return;
    end
    chk("done_timeout", 256'(done_o), 256'(1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 256'({busy_o, done_o, err_o, bus.in_re, bus.w_re, bus.pu_mac_en,
                              bus.pu_relu_en, bus.pu_mac_clear, bus.out_we}), 256'(0));
    chk({tag, "_addr"}, 256'({bus.in_addr, bus.w_addr, bus.out_addr}), 256'(0));
    chk({tag, "_data"}, 256'(bus.out_data), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_i  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal layer.
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    wait_done(200);

    // start_i held through the whole run: one layer only.
    repeat (3) @(negedge clk);
    start_layer(1'b1, NT, NT, layer_off(5), 1'b0);
    wait_done(200);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("single_layer_busy", 256'(busy_o), 256'(0));

    // Back-to-back: restart in the IDLE cycle right after done_o.
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    wait_done(200);
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    wait_done(200);

    // Reset during FEED of tile 1 (cycle 15).
    repeat (3) @(negedge clk);
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    repeat (15) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst_i = 1'b0;
    chk("no_tile1_store", 256'(exp_out_q.size()), 256'(1));
    chk("no_done_after_rst", 256'(exp_done_q.size()), 256'(1));
    exp_in_q.delete();
    exp_w_q.delete();
    exp_din_q.delete();
    exp_out_q.delete();
    exp_done_q.delete();
    exp_relu_n -= 1;
    repeat (8) @(negedge clk);
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    wait_done(200);

    // Spurious pu_done in FEED (cycle 2) and DRAIN (cycle 6).
    repeat (3) @(negedge clk);
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_done(200);

    // Slow PU: done 20 cycles after relu_en.
    repeat (3) @(negedge clk);
    pu_delay = 20;
    start_layer(1'b0, NT, NT, layer_off(20), 1'b0);
    wait_done(300);
    pu_delay = 5;

`ifdef PU_TIMEOUT_EN
    // PU never completes: watchdog after 16 WAIT cycles, no store.
    repeat (3) @(negedge clk);
    pu_never = 1'b1;
    start_layer(1'b0, 1, 0, int'(IN_LEN) + 3 + 1 + int'(TO), 1'b1);
    wait_done(200);
    pu_never = 1'b0;
    @(negedge clk);
    chk("err_sticky", 256'(err_o), 256'(1));
    start_layer(1'b0, NT, NT, layer_off(5), 1'b0);
    @(negedge clk);
    chk("err_cleared", 256'(err_o), 256'(0));
    wait_done(200);
`endif

    repeat (5) @(negedge clk);
    chk("queues_drained", 256'(exp_in_q.size() + exp_w_q.size() + exp_din_q.size() +
                              exp_out_q.size() + exp_done_q.size()), 256'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
